// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with programmable almost-full/empty
// thresholds, an optional first-word-fall-through read port and sticky error flags.
module param_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              full_s;
  logic              empty_s;
  logic              wr_acc_s;
  logic              rd_acc_s;

  // Status flags and accept qualifiers, all derived from the registered count.
  always_comb begin
    full_s   = (count_r == DEPTH_C);
    empty_s  = (count_r == {CW{1'b0}});
    wr_acc_s = wr_en && !full_s;
    rd_acc_s = rd_en && !empty_s;
  end

  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers wrap modulo DEPTH through natural overflow of their width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_acc_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Occupancy: moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky errors; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && full_s)  overflow_r <= 1'b1;
      else if (clr_err)     overflow_r <= 1'b0;
      if (rd_en && empty_s) underflow_r <= 1'b1;
      else if (clr_err)     underflow_r <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem_r[rd_ptr_r];
    end else begin : g_std
      logic [DATA_W-1:0] data_out_r;
      // Registered read port: captures the head word on an accepted pop.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_out_r <= {DATA_W{1'b0}};
        end else if (rd_acc_s) begin
          data_out_r <= mem_r[rd_ptr_r];
        end
      end
      assign data_out = data_out_r;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a standard-read and an FWFT instance share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_param_fifo;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf, m_unf;
  logic [7:0] m_dout0;

  param_fifo #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0),
    .clr_err(clr_err));

  param_fifo #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1),
    .clr_err(clr_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_dout0 = 8'h00;
  endtask

  // Apply the FIFO rules to the inputs sampled at this edge.
  task automatic model_edge();
    bit was_full, was_empty;
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    if (rd_en && !was_empty) begin
      m_dout0 = q[0];
      void'(q.pop_front());
    end
    if (wr_en && !was_full) q.push_back(data_in);
    if (wr_en && was_full) m_ovf = 1'b1;
    else if (clr_err)      m_ovf = 1'b0;
    if (rd_en && was_empty) m_unf = 1'b1;
    else if (clr_err)       m_unf = 1'b0;
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("count0", cnt0, n);
    chk("count1", cnt1, n);
    chk("full0", full0, n == 8);
    chk("empty0", empty0, n == 0);
    chk("af0", af0, n >= 6);
    chk("ae0", ae0, n <= 1);
    chk("ovf0", ovf0, m_ovf);
    chk("unf0", unf0, m_unf);
    chk("flags1", {full1, empty1, af1, ae1, ovf1, unf1},
        {n == 8, n == 0, n >= 6, n <= 1, m_ovf, m_unf});
    chk("dout0", dout0, m_dout0);
    if (n != 0) chk("dout1_fwft", dout1, q[0]);
  end

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", cnt0, 0);
    chk("rst_flags", {empty0, full0, ae0, af0, ovf0, unf0}, 6'b101000);
    chk("rst_dout", dout0, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
      chk("fill_count", cnt0, i);
      chk("fill_ae", ae0, i <= 1);
      chk("fill_af", af0, i >= 6);
      chk("fill_full", full0, i == 8);
    end
    chk("fill_ovf", ovf0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    chk("ovf_set", ovf0, 1'b1);
    chk("ovf_count", cnt0, 8);

    // Drain; each word one cycle after rd_en, 0x99 never appears
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_dout", dout0, 8'(8'h11 * i));
    end
    chk("drain_empty", empty0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", unf0, 1'b1);
    chk("unf_dout_hold", dout0, 8'h88);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_err", {ovf0, unf0}, 2'b00);

    // Streaming at count=4 across pointer wrap
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      step(1'b1, 8'(j + 5), 1'b1, 1'b0);
      chk("stream_count", cnt0, 4);
      chk("stream_dout", dout0, 8'(j + 1));
    end

    // Full with both requests
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("refill_full", full0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("fullrw_count", cnt0, 7);
    chk("fullrw_ovf", ovf0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Empty with both requests: write only, no bypass
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("emptyrw_count", cnt0, 1);
    chk("emptyrw_unf", unf0, 1'b1);
    chk("emptyrw_empty", empty0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("emptyrw_pop", dout0, 8'h5A);

    // FWFT head word visible with no rd_en
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_show", dout1, 8'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fwft_hold", dout1, 8'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", empty1, 1'b1);

    // Asynchronous reset mid-fill at count=5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("pre_rst_count", cnt0, 5);
    #1;
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    model_reset();
    #1;
    chk("arst_count", cnt0, 0);
    chk("arst_flags", {empty1, empty0, ae0, af0, full0}, 5'b11100);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_fwft", dout1, 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_dout", dout0, 8'h3C);
    chk("post_rst_empty", empty0, 1'b1);

    // Randomised phases alternating write-heavy and read-heavy traffic
    for (int i = 0; i < 800; i++) begin
      int pw, pr;
      pw = ((i / 40) % 2 == 0) ? 80 : 30;
      pr = ((i / 40) % 2 == 0) ? 30 : 80;
      step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
           $urandom_range(0, 31) == 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
